// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a load/ready handshake and per-bit strobes.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LEN_C = CW'(FRAME_LEN);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    cnt;
  logic             data_bit;
  logic             next_bit;
  logic             last_bit;
  logic             emit;
  logic             take;

  assign data_bit      = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg[WIDTH-1:1]};
  assign last_bit      = (cnt == ONE_C);
  assign take          = load_valid && load_ready;

`ifdef PISO_PARITY_EN
  logic par;

  // Parity is taken from the captured word and sent once the data bits are exhausted.
  always_ff @(posedge clk) begin
    if (take) par <= ^load_data;
  end

  assign next_bit = last_bit ? par : data_bit;
`else
  assign next_bit = data_bit;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = SHIFT;
      SHIFT:   if (shift_en && last_bit && !load_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The last-bit cycle doubles as a load slot so frames can run back to back.
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    emit       = 1'b0;
    case (state)
      IDLE:  load_ready = 1'b1;
      SHIFT: begin
        busy       = 1'b1;
        emit       = shift_en;
        load_ready = shift_en && last_bit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg       <= '0;
      cnt         <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      sout_valid  <= emit;
      frame_start <= emit && (cnt == LEN_C);
      frame_last  <= emit && last_bit;
      if (emit) begin
        sout  <= next_bit;
        shreg <= shreg_shifted;
        cnt   <= cnt - ONE_C;
      end
      if (take) begin
        shreg <= load_data;
        cnt   <= LEN_C;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances share stimulus.
// Honours PISO_PARITY_EN so the reference frames match the build.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         shift_en;
  logic ready_m, sout_m, valid_m, start_m, last_m, busy_m;
  logic ready_l, sout_l, valid_l, start_l, last_l, busy_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_m),
    .load_data(load_data), .shift_en(shift_en), .sout(sout_m),
    .sout_valid(valid_m), .frame_start(start_m), .frame_last(last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_l),
    .load_data(load_data), .shift_en(shift_en), .sout(sout_l),
    .sout_valid(valid_l), .frame_start(start_l), .frame_last(last_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic bm;
    logic bl;
    logic s;
    logic l;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   rem    = 0;
  logic exp_valid = 1'b0;
  logic hold_m = 1'b0;
  logic hold_l = 1'b0;
  logic mon_en = 1'b0;
  logic last_r = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference frame: data bits in both orders, then parity when enabled.
  task automatic push_frame(input logic [W-1:0] d);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.bm = d[W-1-i];
      e.bl = d[i];
      e.s  = (i == 0);
      e.l  = (i == FL - 1);
      q.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.bm = ^d;
    e.bl = ^d;
    e.s  = 1'b0;
    e.l  = 1'b1;
    q.push_back(e);
`endif
  endtask

  task automatic step(input logic r, input logic lv, input logic [W-1:0] d, input logic se);
    logic accept;
    logic exp_ready;
    @(negedge clk);
    rst        = r;
    load_valid = lv;
    load_data  = d;
    shift_en   = se;
    #1;
    if (mon_en && !last_r) begin
      chk("rst_sout_m", sout_m, 1'b0);   chk("rst_sout_l", sout_l, 1'b0);
      chk("rst_valid_m", valid_m, 1'b0); chk("rst_valid_l", valid_l, 1'b0);
      chk("rst_start_m", start_m, 1'b0); chk("rst_start_l", start_l, 1'b0);
      chk("rst_last_m", last_m, 1'b0);   chk("rst_last_l", last_l, 1'b0);
      chk("rst_busy_m", busy_m, 1'b0);   chk("rst_busy_l", busy_l, 1'b0);
    end
    if (!r) begin
      rem       = 0;
      q.delete();
      hold_m    = 1'b0;
      hold_l    = 1'b0;
      exp_valid = 1'b0;
    end else begin
      exp_ready = (rem == 0) || (rem == 1 && se);
      if (mon_en) begin
        chk("load_ready_m", ready_m, exp_ready);
        chk("load_ready_l", ready_l, exp_ready);
        chk("busy_m", busy_m, rem > 0);
        chk("busy_l", busy_l, rem > 0);
      end
      exp_valid = se && (rem > 0);
      accept    = lv && exp_ready;
      if (se && rem > 0) rem--;
      if (accept) begin
        rem = FL;
        push_frame(d);
      end
    end
    last_r = r;
  endtask

  // Monitor: every cycle, compare emitted bits against the scoreboard or check hold.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("sout_valid_m", valid_m, exp_valid);
      chk("sout_valid_l", valid_l, exp_valid);
      if (valid_m || valid_l) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit at %0t: got a valid bit expected none", $time);
        end else begin
          mon_e = q.pop_front();
          chk("sout_m", sout_m, mon_e.bm);
          chk("sout_l", sout_l, mon_e.bl);
          chk("frame_start_m", start_m, mon_e.s);
          chk("frame_start_l", start_l, mon_e.s);
          chk("frame_last_m", last_m, mon_e.l);
          chk("frame_last_l", last_l, mon_e.l);
          hold_m = mon_e.bm;
          hold_l = mon_e.bl;
        end
      end else begin
        chk("hold_sout_m", sout_m, hold_m);
        chk("hold_sout_l", sout_l, hold_l);
        chk("idle_start_m", start_m, 1'b0);
        chk("idle_last_m", last_m, 1'b0);
        chk("idle_start_l", start_l, 1'b0);
        chk("idle_last_l", last_l, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout at %0t: got no finish expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    shift_en   = 1'b0;

    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    mon_en = 1'b1;
    // Reset wins over a simultaneous load and shift.
    step(1'b0, 1'b1, 8'hC1, 1'b1);

    // Continuous shifting of one word.
    step(1'b1, 1'b1, 8'hC1, 1'b1);
    repeat (FL + 2) step(1'b1, 1'b0, 8'h00, 1'b1);

    // Stalled shifting: strobe every third cycle.
    step(1'b1, 1'b1, 8'hC1, 1'b0);
    for (int i = 0; i < 3 * FL + 3; i++) step(1'b1, 1'b0, 8'h00, (i % 3) == 0);

    // Back-to-back: next word offered throughout, taken only in the last-bit cycle.
    step(1'b1, 1'b1, 8'hC1, 1'b1);
    repeat (FL) step(1'b1, 1'b1, 8'h3E, 1'b1);
    repeat (FL + 2) step(1'b1, 1'b0, 8'h00, 1'b1);

    // Reset mid-frame after three bits, then a fresh frame.
    step(1'b1, 1'b1, 8'hC1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h3E, 1'b1);
    repeat (FL + 2) step(1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) != 0, ($urandom % 3) == 0, W'($urandom),
           ($urandom % 4) != 0);
    end

    repeat (FL + 4) step(1'b1, 1'b0, 8'h00, 1'b1);
    chk_int("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
